// File: rtl/sram_model.sv
// Behavioural SRAM model with a registered read-latency state machine.
// The controller writes by pulling SRAM_WE_N low with data on SRAM_DQ. It reads by
// holding a stable address with SRAM_WE_N high. After READ_LATENCY edges of a stable
// address the model drives SRAM_DQ and raises rd_valid. It releases the bus
// combinationally as soon as SRAM_WE_N falls or reset asserts, so there is no contention.
module sram_model #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 64,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    input  logic              SRAM_WE_N,
    output logic              rd_valid
);

    // Only the low log2(DEPTH) address bits select a word, so addresses alias modulo DEPTH.
    localparam int IDX_W = $clog2(DEPTH);

    // The latency target is held in the same 4-bit width as the counter.
    localparam logic [3:0] RL = 4'(READ_LATENCY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRIVE = 2'd2
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [3:0]         cnt_q;
    logic [3:0]         cnt_d;
    logic [ADDR_W-1:0]  rdAddr_q;
    logic [ADDR_W-1:0]  rdAddr_d;
    logic [3:0]         cntInc;
    logic               addrSame;
    logic               driveEn;
    logic [DATA_W-1:0]  rdData;

    // Storage array. It is deliberately never reset, so unwritten words read as X.
    logic [DATA_W-1:0]  mem [DEPTH];

    assign cntInc   = cnt_q + 4'd1;
    assign addrSame = (SRAM_ADDR == rdAddr_q);

    // Next-state logic.
    // A write edge always aborts any read in progress.
    // A new or changed address restarts the latency count at 1.
    // The count advances while the address stays stable.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdAddr_d = rdAddr_q;
        if (!SRAM_WE_N) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    rdAddr_d = SRAM_ADDR;
                    cnt_d    = 4'd1;
                    state_d  = (RL == 4'd1) ? DRIVE : WAIT;
                end
                WAIT: begin
                    if (addrSame) begin
                        cnt_d = cntInc;
                        if (cntInc >= RL) begin
                            state_d = DRIVE;
                        end
                    end else begin
                        rdAddr_d = SRAM_ADDR;
                        cnt_d    = 4'd1;
                        state_d  = WAIT;
                    end
                end
                DRIVE: begin
                    if (!addrSame) begin
                        rdAddr_d = SRAM_ADDR;
                        cnt_d    = 4'd1;
                        state_d  = WAIT;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Control registers reset asynchronously.
    // The memory write lives in the non-reset branch, so a write edge that lands while
    // reset is low is discarded and the stored contents are left untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            rdAddr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdAddr_q <= rdAddr_d;
            if (!SRAM_WE_N) begin
                mem[SRAM_ADDR[IDX_W-1:0]] <= SRAM_DQ;
            end
        end
    end

    // Read data comes straight from the array, so a write to the latched word shows up at once.
    assign rdData = mem[rdAddr_q[IDX_W-1:0]];

    // The output enable is combinational on SRAM_WE_N, so the bus turns around inside the cycle.
    assign driveEn  = (state_q == DRIVE) && (SRAM_WE_N == 1'b1);
    assign rd_valid = driveEn;
    assign SRAM_DQ  = driveEn ? rdData : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_model.sv
// Self-checking bench for sram_model.
// The main instance uses the default parameters and is driven by directed and random
// traffic, checked against a word-array model that counts stable-address edges.
// A second instance with READ_LATENCY = 1 gets a short directed check.
module tb_sram_model;

    localparam int AW    = 17;
    localparam int DW    = 64;
    localparam int DEPTH = 1024;
    localparam int RL    = 4;

    logic           clk = 1'b0;
    logic           rstN;

    logic           weN;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  tbData;
    logic           tbDrive;
    wire  [DW-1:0]  dq;
    logic           rdValid;

    logic           weN1;
    logic [7:0]     addr1;
    logic [DW-1:0]  tbData1;
    logic           tbDrive1;
    wire  [DW-1:0]  dq1;
    logic           rdValid1;

    // Reference model state: word contents, and a run of stable read-address edges.
    logic [DW-1:0]  refMem [DEPTH];
    bit             refWritten [DEPTH];
    int             run;
    logic [AW-1:0]  runAddr;

    int             checkCount = 0;
    int             failCount  = 0;

    assign dq  = tbDrive  ? tbData  : {DW{1'bz}};
    assign dq1 = tbDrive1 ? tbData1 : {DW{1'bz}};

    always #5 clk = ~clk;

    sram_model #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .reset(rstN), .SRAM_DQ(dq), .SRAM_ADDR(addr),
        .SRAM_WE_N(weN), .rd_valid(rdValid)
    );

    sram_model #(
        .ADDR_W(8), .DATA_W(DW), .DEPTH(16), .READ_LATENCY(1)
    ) dut1 (
        .clk(clk), .reset(rstN), .SRAM_DQ(dq1), .SRAM_ADDR(addr1),
        .SRAM_WE_N(weN1), .rd_valid(rdValid1)
    );

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Update the model as a rising edge would.
    // A write stores the bus value and ends any read.
    // A new address starts a run of 1, and a repeated address extends the run.
    task automatic modelEdge();
        if (!rstN) return;
        if (!weN) begin
            refMem[addr[9:0]]     = tbData;
            refWritten[addr[9:0]] = 1'b1;
            run = 0;
        end else if (run == 0 || addr != runAddr) begin
            runAddr = addr;
            run     = 1;
        end else if (run < 1000) begin
            run++;
        end
    endtask

    // Compare outputs against the model with the current inputs applied.
    task automatic checkCycle(input string phase);
        logic expValid;
        expValid = rstN && weN && (run >= RL);
        checkOutput({phase, ".valid"}, DW'(rdValid), DW'(expValid));
        if (expValid && refWritten[runAddr[9:0]])
            checkOutput({phase, ".dq"}, dq, refMem[runAddr[9:0]]);
        if (rstN && !weN)
            checkOutput({phase, ".bus"}, dq, tbData);
    endtask

    // One cycle: drive inputs, check, take the edge, update the model.
    task automatic applyStimulus(input logic newWeN, input logic [AW-1:0] newAddr,
                                 input logic [DW-1:0] newData, input string phase);
        weN     = newWeN;
        addr    = newAddr;
        tbData  = newData;
        tbDrive = ~newWeN;
        #1;
        checkCycle(phase);
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    initial begin
        int k;
        int a;
        int hold;
        logic we;

        rstN = 1'b0; weN = 1'b1; addr = '0; tbData = '0; tbDrive = 1'b0;
        weN1 = 1'b1; addr1 = '0; tbData1 = '0; tbDrive1 = 1'b0;
        run = 0; runAddr = '0;

        #1;
        checkCycle("reset");
        checkOutput("reset1.valid", DW'(rdValid1), '0);
        repeat (2) @(posedge clk);
        #1;
        checkCycle("resetHeld");
        rstN = 1'b1;

        // Basic write then read.
        applyStimulus(1'b0, 17'd5, 64'hDEAD_BEEF_0123_4567, "wr5");
        applyStimulus(1'b0, 17'd6, 64'h1, "wr6");
        repeat (5) applyStimulus(1'b1, 17'd5, '0, "rd5");
        checkOutput("rd5.final", dq, 64'hDEAD_BEEF_0123_4567);

        // Change the address while driving.
        repeat (6) applyStimulus(1'b1, 17'd6, '0, "chg6");
        checkOutput("chg6.final", dq, 64'h1);

        // Bus turnaround: a write while driving.
        applyStimulus(1'b0, 17'd6, 64'h1234_5678_9ABC_DEF0, "turn");
        repeat (5) applyStimulus(1'b1, 17'd6, '0, "turnRd");
        checkOutput("turnRd.final", dq, 64'h1234_5678_9ABC_DEF0);

        // Upper address bits alias.
        applyStimulus(1'b0, 17'd1029, 64'hA5, "wrap");
        repeat (5) applyStimulus(1'b1, 17'd5, '0, "wrapRd");
        checkOutput("wrapRd.final", dq, 64'hA5);

        // Reset mid-read, with a write attempt during reset.
        applyStimulus(1'b0, 17'd5, 64'hCAFE_F00D_0000_0005, "wrR");
        repeat (2) applyStimulus(1'b1, 17'd5, '0, "rdR");
        rstN = 1'b0;
        run  = 0;
        #1;
        checkCycle("rstWait");
        weN = 1'b0; tbData = 64'hBAD0_BAD0_BAD0_BAD0; tbDrive = 1'b1;
        @(posedge clk);
        modelEdge();
        #1;
        checkCycle("rstWr");
        weN = 1'b1; tbDrive = 1'b0;
        #1;
        rstN = 1'b1;
        repeat (5) applyStimulus(1'b1, 17'd5, '0, "rdAfterRst");
        checkOutput("rdAfterRst.final", dq, 64'hCAFE_F00D_0000_0005);
        rstN = 1'b0;
        run  = 0;
        #1;
        checkCycle("rstDrive");
        #1;
        rstN = 1'b1;

        // Randomized traffic over a small word set, with aliased addresses mixed in.
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 17'(i), {$urandom, $urandom}, "init");
        for (int n = 0; n < 60; n++) begin
            k = int'($urandom_range(0, 7));
            a = k;
            if ($urandom_range(0, 2) == 0)
                a = k + 1024 * int'($urandom_range(1, 100));
            hold = int'($urandom_range(1, 7));
            for (int h = 0; h < hold; h++) begin
                we = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
                applyStimulus(we, 17'(a), {$urandom, $urandom}, "rand");
            end
        end

        // Single-cycle-latency instance.
        weN1 = 1'b0; addr1 = 8'd0; tbData1 = 64'h77; tbDrive1 = 1'b1;
        @(posedge clk);
        #1;
        weN1 = 1'b1; tbDrive1 = 1'b0;
        #1;
        checkOutput("rl1.pre", DW'(rdValid1), '0);
        @(posedge clk);
        #1;
        checkOutput("rl1.valid", DW'(rdValid1), DW'(1));
        checkOutput("rl1.dq", dq1, 64'h77);
        weN1 = 1'b0; tbData1 = 64'h88; tbDrive1 = 1'b1;
        #1;
        checkOutput("rl1.turn", DW'(rdValid1), '0);
        @(posedge clk);
        #1;
        weN1 = 1'b1; tbDrive1 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rl1.rd2", dq1, 64'h88);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/sram_model.md
SRAM_MODEL -- requirements
Module: sram_model

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 17, SRAM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 64, SRAM data-bus width.
REQ-003 The block SHALL have parameter DEPTH, default 1024, number of stored words (power of two, at most 2**ADDR_W).
REQ-004 The block SHALL have parameter READ_LATENCY, default 4, cycles of stable read address before data is driven; legal range 1..15.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-006 The block SHALL have port reset, input, 1; reset is asynchronous and active-low (asserted at 0).
REQ-007 The block SHALL have port SRAM_DQ, inout, DATA_W, bidirectional data bus; driven only by this block during a completed read.
REQ-008 The block SHALL have port SRAM_ADDR, input, ADDR_W, word address from the controller.
REQ-009 The block SHALL have port SRAM_WE_N, input, 1, active-low write enable from the controller.
REQ-010 The block SHALL have port rd_valid, output, 1, high exactly while the block drives SRAM_DQ.

Function
REQ-011 The block SHALL index storage with SRAM_ADDR[log2(DEPTH)-1:0]; upper address bits are ignored, so the address wraps modulo DEPTH.
REQ-012 The block SHALL implement a state machine with states IDLE, WAIT, DRIVE and a 4-bit latency counter cnt.
REQ-013 The block SHALL commit mem[addr] <= SRAM_DQ on every rising edge where SRAM_WE_N is sampled 0; repeated edges with WE_N low rewrite the same location.
REQ-014 On any edge with SRAM_WE_N = 0, the block SHALL go to IDLE and clear cnt to 0, regardless of the current state.
REQ-015 In IDLE with SRAM_WE_N = 1, the block SHALL latch SRAM_ADDR into a registered address, set cnt = 1, and go to WAIT.
REQ-016 In WAIT, if SRAM_ADDR equals the latched address, the block SHALL increment cnt; when cnt reaches READ_LATENCY, it SHALL go to DRIVE.
REQ-017 In WAIT or DRIVE, if SRAM_ADDR differs from the latched address, the block SHALL re-latch the address, set cnt = 1, and return to (or stay in) WAIT; rd_valid SHALL deassert on that edge.
REQ-018 In DRIVE, the block SHALL drive SRAM_DQ with mem[latched address], sampled from the array combinationally, so a same-address write is visible.
REQ-019 When READ_LATENCY = 1, the block SHALL go from IDLE to DRIVE directly on the latching edge.
REQ-020 Read latency SHALL be exactly READ_LATENCY rising edges from the first edge at which a stable address with WE_N = 1 is sampled to rd_valid = 1.
REQ-021 The SRAM_DQ output enable SHALL equal (state == DRIVE) AND (SRAM_WE_N == 1), evaluated combinationally, so the block releases the bus in the same cycle WE_N falls (no contention).
REQ-022 Otherwise SRAM_DQ SHALL be high-impedance on all bits.
REQ-023 rd_valid SHALL equal the SRAM_DQ output enable.
REQ-024 Storage SHALL be a DEPTH x DATA_W register array with no per-word reset; uninitialised words read X in simulation.
REQ-025 If SRAM_WE_N is low while SRAM_DQ contains X or Z bits, the block SHALL store those values unchanged.

Reset
REQ-026 While reset = 0, the block SHALL force state = IDLE, cnt = 0, and latched address = 0, asynchronously.
REQ-027 While reset = 0, rd_valid SHALL be 0 and SRAM_DQ SHALL be all-Z.
REQ-028 Reset SHALL NOT alter memory contents; a write edge coincident with reset assertion SHALL be discarded.
REQ-029 If reset asserts mid-read (WAIT or DRIVE), the bus SHALL be released immediately; after release, the full READ_LATENCY count restarts.

Verification
REQ-030 Write/read: WE_N = 0 one edge, ADDR = 5, DQ = 64'hDEAD_BEEF_0123_4567; then WE_N = 1, bus released, ADDR = 5 -> rd_valid rises on the 4th edge and DQ = 64'hDEAD_BEEF_0123_4567.
REQ-031 Address change: in DRIVE at ADDR = 5, change to ADDR = 6 (holding 64'h1) -> rd_valid = 0 next edge, then rd_valid = 1 and DQ = 64'h1 four edges after the change.
REQ-032 Turnaround: in DRIVE, drop WE_N to 0 -> DQ = Z in the same cycle before the next edge; rd_valid = 0; write of the controller's value commits at that edge.
REQ-033 Wrap-around: write 64'hA5 to ADDR = 17'd1029 with DEPTH = 1024, then read ADDR = 5 -> DQ = 64'hA5 after 4 edges.
REQ-034 Reset mid-read: assert reset in WAIT with cnt = 2 -> DQ = Z immediately; deassert, hold ADDR = 5 -> data after 4 edges, contents of ADDR 5 unchanged.
REQ-035 READ_LATENCY = 1 instance: write 64'h77 to ADDR = 0, then read ADDR = 0 -> rd_valid = 1 after the first edge with WE_N = 1.
